stepper_cmd_ctrl: RTL
=====================

Name: stepper_cmd_ctrl

Overview:
- Command-driven sequencer for the rover's stepper drive on the Pmod JA header.
- Accepts move commands (direction, step count, step period) over a valid/ready handshake.
- Times each step with an internal prescaler and drives the 4-bit full-step coil pattern on ja.
- Holds the coils energised briefly after a move, then de-energises them. Runs from the 100 MHz system clock.

Parameters:
- DIV_W, 32: width of the step-period field, in clk cycles.
- CNT_W, 16: width of the step-count field.
- HOLD_CYCLES, 1_000_000: clk cycles the coils stay energised after the last step (10 ms at 100 MHz).

Ports:
- clk  in  1: system clock, 100 MHz.
- reset  in  1: synchronous, active-high reset.
- cmd_valid  in  1: command present.
- cmd_ready  out  1: controller can accept a command.
- cmd_dir  in  1: 1 = forward (phase index +1), 0 = reverse (phase index -1).
- cmd_steps  in  CNT_W: number of steps to take.
- cmd_period  in  DIV_W: clk cycles per step; values below 2 are clamped to 2.
- abort  in  1: stop the current move.
- ja  out  4: coil drive pattern.
- step_tick  out  1: one-cycle pulse on each step.
- busy  out  1: high in RUN or HOLD.
- steps_left  out  CNT_W: steps remaining in the current or last move.
- done  out  1: one-cycle pulse when a move ends (normally, aborted, or zero-length).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset values:
  - State IDLE, phase index 0.
  - ja=4'b0000, cmd_ready=1, busy=0, step_tick=0, done=0, steps_left=0.
  - Prescaler and hold counters 0.
- Phase table (index 0..3): 4'b1100, 4'b0110, 4'b0011, 4'b1001.
  - Index wraps modulo 4 in both directions.
  - Index persists across commands; only reset clears it.
- IDLE:
  - ja=0, cmd_ready=!abort.
  - On cmd_valid && cmd_ready: latch dir, steps and period (clamped to >=2).
    - steps_left <= cmd_steps.
    - Prescaler loaded with period-1.
  - If cmd_steps==0: stay in IDLE, assert done on the next cycle, take no step.
  - Otherwise go to RUN.
- RUN:
  - ja = PHASE[idx]; busy=1; cmd_ready=0.
  - The prescaler decrements each cycle. When it is 0:
    - idx advances per dir; step_tick=1 for that cycle; steps_left decrements; prescaler reloads period-1.
  - First step occurs exactly `period` cycles after the accept edge; each later step follows `period` cycles after the previous one.
  - ja changes on the same edge that step_tick asserts.
  - After the last step (steps_left reaches 0): go to HOLD, hold counter loaded with HOLD_CYCLES-1.
- HOLD:
  - ja holds the last pattern; busy=1; cmd_ready=0.
  - When the hold counter reaches 0: go to IDLE, done=1 for one cycle, ja=0.
- abort in RUN or HOLD:
  - Next edge goes to IDLE with ja=0 and done pulsed.
  - steps_left is retained; a nonzero value indicates the move was cut short.
  - abort takes priority over a coincident step: no tick, idx unchanged.
- abort in IDLE: no effect, except that cmd_ready=0 that cycle, so a coincident command is not accepted.
- cmd_valid held high during RUN/HOLD is ignored. It is accepted on the first IDLE cycle.
- reset mid-move: all outputs and state return to reset values on the next edge.
- Width rules:
  - Prescaler is DIV_W bits and period-1 never underflows because of the clamp.
  - steps_left never decrements below 0.
  - Hold counter width is clog2(HOLD_CYCLES).

Decomposition:
- Package stepper_pkg:
  - State enum {IDLE, RUN, HOLD}.
  - PHASE_TABLE constant (4 x 4-bit).
  - MIN_PERIOD=2.
- One sub-module, step_prescaler: a loadable DIV_W down-counter with a load, enable and zero-tick output. The FSM, step counter, phase index and hold counter stay in stepper_cmd_ctrl.

Test Plan (bench uses HOLD_CYCLES=8):
1. Forward move. Reset, then accept dir=1, steps=3, period=4 at cycle T.
   - step_tick at T+4, T+8 and T+12.
   - ja sequence 0110, 0011, 1001.
   - HOLD for 8 cycles, done at T+20, then ja=0 and cmd_ready=1.
2. Reverse move after scenario 1 (idx=3). Accept dir=0, steps=2, period=2.
   - ja goes 0011 then 0110.
   - step_tick 2 cycles apart.
   - steps_left ends at 0.
3. Zero-length and clamp.
   - steps=0: done one cycle after accept, no step_tick, ja stays 0.
   - Then period=0, steps=1: step_tick exactly 2 cycles after accept.
4. Abort. Accept steps=5, period=4; assert abort on the cycle of the 2nd tick.
   - No 2nd tick.
   - Next edge: IDLE, ja=0, done=1, steps_left=4.
5. Back-pressure. Hold cmd_valid with a second command during RUN and HOLD.
   - cmd_ready stays 0 throughout.
   - The second command is accepted on the first IDLE cycle.
   - Assert abort together with cmd_valid in IDLE: the command is not accepted.
6. Reset mid-RUN. Assert reset between ticks.
   - Next edge gives ja=0, busy=0, steps_left=0, idx=0.
   - The next forward command starts at ja=0110.

Source files
------------

// File: rtl/stepper_cmd_ctrl_pkg.sv
// Shared definitions for the stepper command controller.
// Contents:
//   state_t      - controller state (IDLE, RUN, HOLD)
//   PHASE_TABLE  - full-step coil patterns, index 0..3
//   MIN_PERIOD   - smallest step period accepted, in clk cycles
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Entry [0] is the rightmost element: 1100, 0110, 0011, 1001.
  localparam logic [3:0][3:0] PHASE_TABLE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};

  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/stepper_cmd_ctrl_if.sv
// Move-command handshake bundle for the stepper command controller.
// Signals:
//   cmd_valid  - command present (master -> slave)
//   cmd_ready  - controller can accept a command (slave -> master)
//   cmd_dir    - 1 = forward, 0 = reverse
//   cmd_steps  - number of steps to take
//   cmd_period - clk cycles per step
interface stepper_cmd_ctrl_if #(
  parameter int DIV_W = 32,
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_cmd_ctrl_prescaler.sv
// Loadable down-counter that times the interval between steps.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   load       - load load_val (has priority over en)
//   en         - count down by one while nonzero
//   load_val   - reload value (period - 1)
//   zero       - counter is at zero; the next enabled cycle is a step
module step_prescaler #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic             zero
);

  logic [DIV_W-1:0] count;

  // Down-counter with load priority; holds at zero until reloaded
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {DIV_W{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != {DIV_W{1'b0}})) begin
      count <= count - DIV_W'(1);
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {DIV_W{1'b0}});

endmodule

// File: rtl/stepper_cmd_ctrl.sv
// Command-driven full-step sequencer for the stepper drive on Pmod JA.
// Ports:
//   clk, reset  - 100 MHz clock, synchronous active-high reset
//   cmd         - move-command handshake (slave side)
//   abort       - stop the current move; also blocks acceptance in IDLE
//   ja          - 4-bit coil drive pattern
//   step_tick   - one-cycle pulse on each step (same edge ja changes)
//   busy        - high in RUN or HOLD
//   steps_left  - steps remaining in the current or last move
//   done        - one-cycle pulse when a move ends (normal, aborted, zero-length)
module stepper_cmd_ctrl
  import stepper_pkg::*;
#(
  parameter int DIV_W       = 32,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  stepper_cmd_ctrl_if.slave cmd,
  input  logic              abort,
  output logic [3:0]        ja,
  output logic              step_tick,
  output logic              busy,
  output logic [CNT_W-1:0]  steps_left,
  output logic              done
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t            state;
  logic [1:0]        idx;
  logic [1:0]        idx_next;
  logic              dir;
  logic [DIV_W-1:0]  period_m1;
  logic [DIV_W-1:0]  period_clamped;
  logic [DIV_W-1:0]  presc_load_val;
  logic [HOLD_W-1:0] hold_cnt;
  logic              ready;
  logic              accept;
  logic              step_now;
  logic              presc_load;
  logic              presc_en;
  logic              presc_zero;

  // Clamp the requested period so period-1 can never underflow
  always_comb begin
    if (cmd.cmd_period < DIV_W'(MIN_PERIOD)) begin
      period_clamped = DIV_W'(MIN_PERIOD);
    end else begin
      period_clamped = cmd.cmd_period;
    end
  end

  // Phase index of the next step, wrapping modulo 4 either way
  always_comb begin
    if (dir) begin
      idx_next = idx + 2'd1;
    end else begin
      idx_next = idx - 2'd1;
    end
  end

  // Handshake and prescaler control; abort suppresses both accept and steps
  always_comb begin
    ready          = 1'b0;
    accept         = 1'b0;
    step_now       = 1'b0;
    presc_load     = 1'b0;
    presc_en       = 1'b0;
    presc_load_val = period_m1;
    case (state)
      IDLE: begin
        ready          = !abort;
        accept         = cmd.cmd_valid && !abort;
        presc_load     = accept;
        presc_load_val = period_clamped - DIV_W'(1);
      end
      RUN: begin
        if (!abort) begin
          step_now   = presc_zero;
          presc_load = presc_zero;
          presc_en   = !presc_zero;
        end else begin
          step_now = 1'b0;
        end
      end
      HOLD: begin
        ready = 1'b0;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign cmd.cmd_ready = ready;

  step_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .load     (presc_load),
    .en       (presc_en),
    .load_val (presc_load_val),
    .zero     (presc_zero)
  );

  // Controller FSM with registered coil, status and pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      dir        <= 1'b0;
      period_m1  <= {DIV_W{1'b0}};
      hold_cnt   <= {HOLD_W{1'b0}};
      ja         <= 4'b0000;
      step_tick  <= 1'b0;
      busy       <= 1'b0;
      steps_left <= {CNT_W{1'b0}};
      done       <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          ja   <= 4'b0000;
          busy <= 1'b0;
          if (accept) begin
            dir        <= cmd.cmd_dir;
            period_m1  <= period_clamped - DIV_W'(1);
            steps_left <= cmd.cmd_steps;
            if (cmd.cmd_steps == {CNT_W{1'b0}}) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              ja    <= PHASE_TABLE[idx];
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            ja    <= 4'b0000;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (step_now) begin
            idx       <= idx_next;
            ja        <= PHASE_TABLE[idx_next];
            step_tick <= 1'b1;
            if (steps_left != {CNT_W{1'b0}}) begin
              steps_left <= steps_left - CNT_W'(1);
            end
            // This step is the last one: start the energised hold
            if (steps_left <= CNT_W'(1)) begin
              state    <= HOLD;
              hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            end
          end
        end
        HOLD: begin
          if (abort || (hold_cnt == {HOLD_W{1'b0}})) begin
            state <= IDLE;
            ja    <= 4'b0000;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          ja    <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
